amm_write_gen: RTL and testbench

//  Write-side traffic generator of the memory checker, the counterpart of the read-data comparator.
//  It accepts one write command per handshake and drives Avalon-MM write bursts to memory.

---
 rtl/amm_write_gen_if.sv | 44 ++++
 rtl/amm_write_gen.sv | 168 ++++++++++++++++
 tb/tb_amm_write_gen.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/amm_write_gen_if.sv
// Command and Avalon-MM signal bundle for the write generator.
// The master modport is the generator's view; slave is the command source plus memory side.
interface amm_write_gen_if #(
  parameter int AMM_DATA_W = 32,
  parameter int ADDR_W     = 31,
  parameter int BURST_W    = 11
) ();
  localparam int DATA_B_W = AMM_DATA_W / 8;

  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic [ADDR_W-1:0]     cmd_addr_i;
  logic [15:0]           cmd_word_count_i;
  logic [DATA_B_W-1:0]   cmd_start_mask_i;
  logic [DATA_B_W-1:0]   cmd_middle_mask_i;
  logic [DATA_B_W-1:0]   cmd_end_mask_i;
  logic [7:0]            cmd_data_ptrn_i;
  logic                  cmd_ptrn_mode_i;
  logic                  stop_i;
  logic [ADDR_W-1:0]     amm_address_o;
  logic                  amm_write_o;
  logic [AMM_DATA_W-1:0] amm_writedata_o;
  logic [DATA_B_W-1:0]   amm_byteenable_o;
  logic [BURST_W-1:0]    amm_burstcount_o;
  logic                  amm_waitrequest_i;
  logic                  wr_done_o;
  logic                  busy_o;

  modport master (
    input  cmd_valid_i, cmd_addr_i, cmd_word_count_i, cmd_start_mask_i,
           cmd_middle_mask_i, cmd_end_mask_i, cmd_data_ptrn_i, cmd_ptrn_mode_i,
           stop_i, amm_waitrequest_i,
    output cmd_ready_o, amm_address_o, amm_write_o, amm_writedata_o,
           amm_byteenable_o, amm_burstcount_o, wr_done_o, busy_o
  );

  modport slave (
    output cmd_valid_i, cmd_addr_i, cmd_word_count_i, cmd_start_mask_i,
           cmd_middle_mask_i, cmd_end_mask_i, cmd_data_ptrn_i, cmd_ptrn_mode_i,
           stop_i, amm_waitrequest_i,
    input  cmd_ready_o, amm_address_o, amm_write_o, amm_writedata_o,
           amm_byteenable_o, amm_burstcount_o, wr_done_o, busy_o
  );
endinterface

// File: rtl/amm_write_gen.sv
// Avalon-MM write burst generator: splits one command into bursts of at most MAX_BURST words,
// with fixed or LFSR byte patterns and start/middle/end byteenables.
module amm_write_gen #(
  parameter int    AMM_DATA_W = 32,
  parameter int    ADDR_W     = 31,
  parameter string ADDR_TYPE  = "BYTE",
  parameter int    BURST_W    = 11,
  parameter int    MAX_BURST  = 4
) (
  input logic            clk_i,
  input logic            rst_i,
  amm_write_gen_if.master bus
);
  localparam int DATA_B_W = AMM_DATA_W / 8;
  localparam int ADDR_B_W = $clog2(DATA_B_W);
  localparam bit IS_BYTE  = (ADDR_TYPE == "BYTE");
  localparam logic [ADDR_W-1:0] ALIGN_MASK = IS_BYTE ? ~ADDR_W'(DATA_B_W - 1) : '1;

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [15:0]          count_q, count_d;
  logic [15:0]          remaining_q, remaining_d;
  logic [15:0]          word_idx_q, word_idx_d;
  logic [BURST_W-1:0]   beats_left_q, beats_left_d;
  logic [BURST_W-1:0]   burstcount_q, burstcount_d;
  logic [7:0]           ptrn_q, ptrn_d;
  logic                 mode_q, mode_d;
  logic [DATA_B_W-1:0]  start_mask_q, start_mask_d;
  logic [DATA_B_W-1:0]  mid_mask_q, mid_mask_d;
  logic [DATA_B_W-1:0]  end_mask_q, end_mask_d;
  logic                 stop_seen_q, stop_seen_d;
  logic                 wr_done_q, wr_done_d;
  logic [BURST_W-1:0]   bc;
  logic [ADDR_W-1:0]    addr_step;
  logic [DATA_B_W-1:0]  be;
  logic                 in_burst;

  function automatic logic [BURST_W-1:0] burst_len(input logic [15:0] rem);
    if (rem > 16'(MAX_BURST)) return BURST_W'(MAX_BURST);
    return BURST_W'(rem);
  endfunction

  // Words (WORD) or bytes (BYTE) covered by the burst that just finished.
  assign addr_step = IS_BYTE ? (ADDR_W'(burstcount_q) << ADDR_B_W) : ADDR_W'(burstcount_q);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    count_d      = count_q;
    remaining_d  = remaining_q;
    word_idx_d   = word_idx_q;
    beats_left_d = beats_left_q;
    burstcount_d = burstcount_q;
    ptrn_d       = ptrn_q;
    mode_d       = mode_q;
    start_mask_d = start_mask_q;
    mid_mask_d   = mid_mask_q;
    end_mask_d   = end_mask_q;
    stop_seen_d  = stop_seen_q;
    bc           = '0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid_i && bus.cmd_word_count_i != 16'd0) begin
          bc           = burst_len(bus.cmd_word_count_i);
          addr_d       = bus.cmd_addr_i & ALIGN_MASK;
          count_d      = bus.cmd_word_count_i;
          remaining_d  = bus.cmd_word_count_i - 16'(bc);
          word_idx_d   = 16'd0;
          beats_left_d = bc;
          burstcount_d = bc;
          ptrn_d       = bus.cmd_data_ptrn_i;
          mode_d       = bus.cmd_ptrn_mode_i;
          start_mask_d = bus.cmd_start_mask_i;
          mid_mask_d   = bus.cmd_middle_mask_i;
          end_mask_d   = bus.cmd_end_mask_i;
          stop_seen_d  = bus.stop_i;
          state_d      = S_BURST;
        end
      end
      S_BURST: begin
        if (bus.stop_i) stop_seen_d = 1'b1;
        if (!bus.amm_waitrequest_i) begin
          word_idx_d   = word_idx_q + 16'd1;
          beats_left_d = beats_left_q - BURST_W'(1);
          if (mode_q) ptrn_d = {ptrn_q[6:0], ptrn_q[6] ^ ptrn_q[1] ^ ptrn_q[0]};
          if (beats_left_q == BURST_W'(1)) begin
            if (remaining_q == 16'd0 || stop_seen_q || bus.stop_i) begin
              state_d = S_DONE;
            end else begin
              addr_d  = addr_q + addr_step;
              state_d = S_GAP;
            end
          end
        end
      end
      S_GAP: begin
        if (bus.stop_i || stop_seen_q) begin
          state_d = S_DONE;
        end else begin
          bc           = burst_len(remaining_q);
          remaining_d  = remaining_q - 16'(bc);
          beats_left_d = bc;
          burstcount_d = bc;
          state_d      = S_BURST;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered so the pulse lands one cycle after the DONE state.
  assign wr_done_d = (state_q == S_DONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      count_q      <= '0;
      remaining_q  <= '0;
      word_idx_q   <= '0;
      beats_left_q <= '0;
      burstcount_q <= '0;
      ptrn_q       <= '0;
      mode_q       <= 1'b0;
      start_mask_q <= '0;
      mid_mask_q   <= '0;
      end_mask_q   <= '0;
      stop_seen_q  <= 1'b0;
      wr_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      remaining_q  <= remaining_d;
      word_idx_q   <= word_idx_d;
      beats_left_q <= beats_left_d;
      burstcount_q <= burstcount_d;
      ptrn_q       <= ptrn_d;
      mode_q       <= mode_d;
      start_mask_q <= start_mask_d;
      mid_mask_q   <= mid_mask_d;
      end_mask_q   <= end_mask_d;
      stop_seen_q  <= stop_seen_d;
      wr_done_q    <= wr_done_d;
    end
  end

  // Byteenable selection uses the word's position within the whole command.
  always_comb begin
    if (count_q == 16'd1)                    be = mid_mask_q;
    else if (word_idx_q == 16'd0)            be = start_mask_q;
    else if (word_idx_q == count_q - 16'd1)  be = end_mask_q;
    else                                     be = '1;
  end

  assign in_burst             = (state_q == S_BURST);
  assign bus.cmd_ready_o      = (state_q == S_IDLE) && !rst_i;
  assign bus.amm_address_o    = addr_q;
  assign bus.amm_write_o      = in_burst;
  assign bus.amm_writedata_o  = in_burst ? {DATA_B_W{ptrn_q}} : '0;
  assign bus.amm_byteenable_o = in_burst ? be : '0;
  assign bus.amm_burstcount_o = in_burst ? burstcount_q : '0;
  assign bus.wr_done_o        = wr_done_q;
  assign bus.busy_o           = (state_q != S_IDLE);
endmodule

// File: tb/tb_amm_write_gen.sv
// Scoreboard bench for amm_write_gen: expected beats are queued from a command model
// and popped by a beat monitor as the generator writes them.
module tb_amm_write_gen;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  amm_write_gen_if #(.AMM_DATA_W(32), .ADDR_W(31), .BURST_W(11)) bus ();

  amm_write_gen #(
    .AMM_DATA_W(32), .ADDR_W(31), .ADDR_TYPE("BYTE"), .BURST_W(11), .MAX_BURST(4)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  typedef struct packed {
    logic [30:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [10:0] bc;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    beat_cnt = 0;
  int    last_beat_cyc = 0;
  int    stall_cnt = 0;
  int    stall_at = -1;
  int    stall_len = 0;
  int    stop_at = -1;
  bit    stalled_prev = 1'b0;
  beat_t held;

  function automatic beat_t cur_beat();
    return {bus.amm_address_o, bus.amm_writedata_o, bus.amm_byteenable_o, bus.amm_burstcount_o};
  endfunction

  function automatic logic [7:0] lfsr(input logic [7:0] p);
    return {p[6:0], p[6] ^ p[1] ^ p[0]};
  endfunction

  always @(posedge clk_i) cyc <= cyc + 1;

  // Beat monitor: scoreboard pop on every accepted beat, hold check after every stalled cycle.
  always @(negedge clk_i) begin
    beat_t got;
    beat_t e;
    got = cur_beat();
    if (stalled_prev && bus.amm_write_o) begin
      n_checks++;
      stall_cnt++;
      if (got !== held) begin
        n_fail++;
        $display("FAIL stall_hold: got %h required %h", got, held);
      end
    end
    if (bus.amm_write_o && !bus.amm_waitrequest_i) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: got %h required no beat", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL beat: addr %h data %h be %b bc %0d required addr %h data %h be %b bc %0d",
                   got.addr, got.data, got.be, got.bc, e.addr, e.data, e.be, e.bc);
        end
      end
      beat_cnt++;
      last_beat_cyc = cyc;
    end
    stalled_prev = bus.amm_write_o && bus.amm_waitrequest_i;
    held = got;
  end

  task automatic push_expected(input logic [30:0] addr, input int count, input logic [3:0] sm,
                               input logic [3:0] mm, input logic [3:0] em, input logic [7:0] ptrn,
                               input bit mode, input int max_bursts);
    logic [30:0] a;
    logic [7:0]  p;
    int          k;
    int          nb;
    int          bcnt;
    beat_t       e;
    a = addr & ~31'h3;
    p = ptrn;
    k = 0;
    nb = 0;
    while (k < count && nb < max_bursts) begin
      bcnt = (count - k > 4) ? 4 : count - k;
      for (int j = 0; j < bcnt; j++) begin
        e.addr = a;
        e.data = {4{p}};
        e.bc   = 11'(bcnt);
        if (count == 1)          e.be = mm;
        else if (k == 0)         e.be = sm;
        else if (k == count - 1) e.be = em;
        else                     e.be = 4'hF;
        exp_q.push_back(e);
        if (mode) p = lfsr(p);
        k++;
      end
      a = a + 31'(bcnt * 4);
      nb++;
    end
  endtask

  task automatic issue_cmd(input logic [30:0] addr, input int count, input logic [3:0] sm,
                           input logic [3:0] mm, input logic [3:0] em, input logic [7:0] ptrn,
                           input bit mode, input bit stop_with, output bit accepted);
    @(posedge clk_i); #1;
    beat_cnt = 0;
    stall_cnt = 0;
    bus.cmd_addr_i        = addr;
    bus.cmd_word_count_i  = 16'(count);
    bus.cmd_start_mask_i  = sm;
    bus.cmd_middle_mask_i = mm;
    bus.cmd_end_mask_i    = em;
    bus.cmd_data_ptrn_i   = ptrn;
    bus.cmd_ptrn_mode_i   = mode;
    bus.stop_i            = stop_with;
    bus.cmd_valid_i       = 1'b1;
    @(negedge clk_i);
    accepted = bus.cmd_ready_o;
    @(posedge clk_i); #1;
    bus.cmd_valid_i = 1'b0;
    bus.stop_i      = 1'b0;
  endtask

  task automatic run_until_done(input int budget, output bit seen, output int idle, output int done_cyc);
    int stall_used;
    bit stop_used;
    seen = 1'b0;
    idle = 0;
    done_cyc = 0;
    stall_used = 0;
    stop_used = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.wr_done_o) begin
        seen = 1'b1;
        done_cyc = cyc;
        break;
      end
      if (bus.busy_o && !bus.amm_write_o && beat_cnt > 0) idle++;
      bus.amm_waitrequest_i = bus.amm_write_o && beat_cnt == stall_at && stall_used < stall_len;
      if (bus.amm_waitrequest_i) stall_used++;
      bus.stop_i = stop_at >= 0 && !stop_used && bus.amm_write_o && beat_cnt == stop_at;
      if (bus.stop_i) stop_used = 1'b1;
      @(posedge clk_i); #1;
    end
    bus.amm_waitrequest_i = 1'b0;
    bus.stop_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if ({bus.cmd_ready_o, bus.amm_write_o, bus.busy_o, bus.wr_done_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: ready/write/busy/done %b required 0000",
               {bus.cmd_ready_o, bus.amm_write_o, bus.busy_o, bus.wr_done_o});
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if ({bus.cmd_ready_o, bus.amm_write_o, bus.busy_o} !== 3'b100) begin
      n_fail++;
      $display("FAIL after_reset: ready/write/busy %b required 100",
               {bus.cmd_ready_o, bus.amm_write_o, bus.busy_o});
    end
  endtask

  task automatic test_single();
    bit acc, seen;
    int idle, dc;
    push_expected(31'h40, 1, 4'b0000, 4'b0110, 4'b0000, 8'hA5, 1'b0, 99);
    issue_cmd(31'h40, 1, 4'b0000, 4'b0110, 4'b0000, 8'hA5, 1'b0, 1'b0, acc);
    n_checks++;
    if ({acc, bus.amm_write_o, bus.busy_o} !== 3'b111) begin
      n_fail++;
      $display("FAIL single_latency: accepted/write/busy %b required 111", {acc, bus.amm_write_o, bus.busy_o});
    end
    run_until_done(50, seen, idle, dc);
    n_checks++;
    if (!seen || dc - last_beat_cyc != 2) begin
      n_fail++;
      $display("FAIL single_done: seen %0d gap %0d required seen 1 gap 2", seen, dc - last_beat_cyc);
    end
    @(posedge clk_i); #1;
    n_checks++;
    if (bus.wr_done_o !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL single_pulse: done %b left %0d required done 0 left 0", bus.wr_done_o, exp_q.size());
    end
  endtask

  task automatic test_bursts();
    bit acc, seen;
    int idle, dc;
    push_expected(31'h100, 10, 4'b1100, 4'b0000, 4'b0011, 8'h3C, 1'b0, 99);
    issue_cmd(31'h100, 10, 4'b1100, 4'b0000, 4'b0011, 8'h3C, 1'b0, 1'b0, acc);
    run_until_done(100, seen, idle, dc);
    n_checks++;
    if (!seen || beat_cnt != 10 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bursts_done: seen %0d beats %0d left %0d required 1 10 0", seen, beat_cnt, exp_q.size());
    end
    n_checks++;
    if (idle != 3) begin
      n_fail++;
      $display("FAIL bursts_gaps: idle busy cycles %0d required 3", idle);
    end
  endtask

  task automatic test_stall();
    bit acc, seen;
    int idle, dc;
    stall_at = 1;
    stall_len = 2;
    push_expected(31'h200, 3, 4'b0001, 4'b0000, 4'b1000, 8'h01, 1'b1, 99);
    issue_cmd(31'h200, 3, 4'b0001, 4'b0000, 4'b1000, 8'h01, 1'b1, 1'b0, acc);
    run_until_done(100, seen, idle, dc);
    stall_at = -1;
    n_checks++;
    if (!seen || stall_cnt != 2 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_done: seen %0d held %0d left %0d required 1 2 0", seen, stall_cnt, exp_q.size());
    end
  endtask

  task automatic test_stop();
    bit acc, seen;
    int idle, dc;
    stop_at = 2;
    push_expected(31'h300, 10, 4'b1110, 4'b0000, 4'b0111, 8'h5A, 1'b1, 1);
    issue_cmd(31'h300, 10, 4'b1110, 4'b0000, 4'b0111, 8'h5A, 1'b1, 1'b0, acc);
    run_until_done(100, seen, idle, dc);
    stop_at = -1;
    n_checks++;
    if (!seen || beat_cnt != 4 || exp_q.size() != 0 || bus.cmd_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_mid: seen %0d beats %0d left %0d ready %b required 1 4 0 1",
               seen, beat_cnt, exp_q.size(), bus.cmd_ready_o);
    end
    push_expected(31'h380, 10, 4'b1000, 4'b0000, 4'b0001, 8'h11, 1'b0, 1);
    issue_cmd(31'h380, 10, 4'b1000, 4'b0000, 4'b0001, 8'h11, 1'b0, 1'b1, acc);
    run_until_done(100, seen, idle, dc);
    n_checks++;
    if (!seen || beat_cnt != 4 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stop_accept: seen %0d beats %0d left %0d required 1 4 0", seen, beat_cnt, exp_q.size());
    end
  endtask

  task automatic test_zero();
    bit acc;
    int bad;
    bad = 0;
    issue_cmd(31'h500, 0, 4'hF, 4'hF, 4'hF, 8'h77, 1'b0, 1'b0, acc);
    for (int i = 0; i < 6; i++) begin
      if (bus.amm_write_o || bus.busy_o || bus.wr_done_o || !bus.cmd_ready_o) bad++;
      @(posedge clk_i); #1;
    end
    n_checks++;
    if (!acc || bad != 0 || beat_cnt != 0) begin
      n_fail++;
      $display("FAIL zero_count: accepted %0d bad cycles %0d beats %0d required 1 0 0", acc, bad, beat_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit acc, seen;
    int idle, dc, n, done_cnt;
    push_expected(31'h400, 4, 4'b0011, 4'b0000, 4'b1100, 8'hC3, 1'b0, 99);
    issue_cmd(31'h400, 4, 4'b0011, 4'b0000, 4'b1100, 8'hC3, 1'b0, 1'b0, acc);
    n = 0;
    while (beat_cnt < 2 && n < 20) begin
      @(posedge clk_i); #1;
      n++;
    end
    n_checks++;
    if (beat_cnt != 2 || !bus.amm_write_o) begin
      n_fail++;
      $display("FAIL rstmid_reach: beats %0d write %b required 2 1", beat_cnt, bus.amm_write_o);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (bus.cmd_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_ready: ready %b required 0", bus.cmd_ready_o);
    end
    @(posedge clk_i); #1;
    n_checks++;
    if (bus.amm_write_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_release: write %b busy %b required 0 0", bus.amm_write_o, bus.busy_o);
    end
    rst_i = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.wr_done_o) done_cnt++;
      @(posedge clk_i); #1;
    end
    n_checks++;
    if (done_cnt != 0 || exp_q.size() != 1) begin
      n_fail++;
      $display("FAIL rstmid_nodone: done pulses %0d left %0d required 0 1", done_cnt, exp_q.size());
    end
    exp_q.delete();
    push_expected(31'h480, 2, 4'b0101, 4'b0000, 4'b1010, 8'h99, 1'b1, 99);
    issue_cmd(31'h480, 2, 4'b0101, 4'b0000, 4'b1010, 8'h99, 1'b1, 1'b0, acc);
    run_until_done(50, seen, idle, dc);
    n_checks++;
    if (!acc || !seen || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rstmid_recover: accepted %0d seen %0d left %0d required 1 1 0", acc, seen, exp_q.size());
    end
  endtask

  task automatic test_wrap();
    bit acc, seen;
    int idle, dc;
    push_expected(31'h7FFF_FFF9, 6, 4'b0111, 4'b0000, 4'b1110, 8'h80, 1'b1, 99);
    issue_cmd(31'h7FFF_FFF9, 6, 4'b0111, 4'b0000, 4'b1110, 8'h80, 1'b1, 1'b0, acc);
    run_until_done(100, seen, idle, dc);
    n_checks++;
    if (!seen || beat_cnt != 6 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL wrap: seen %0d beats %0d left %0d required 1 6 0", seen, beat_cnt, exp_q.size());
    end
  endtask

  initial begin
    bus.cmd_valid_i       = 1'b0;
    bus.cmd_addr_i        = '0;
    bus.cmd_word_count_i  = '0;
    bus.cmd_start_mask_i  = '0;
    bus.cmd_middle_mask_i = '0;
    bus.cmd_end_mask_i    = '0;
    bus.cmd_data_ptrn_i   = '0;
    bus.cmd_ptrn_mode_i   = 1'b0;
    bus.stop_i            = 1'b0;
    bus.amm_waitrequest_i = 1'b0;
    test_reset();
    test_single();
    test_bursts();
    test_stall();
    test_stop();
    test_zero();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
